// File: rtl/dlx_pkg.sv
// Definitions shared by the DLX fetch unit, the control decoder and their benches:
// instruction word geometry, field offsets and the canonical nop encoding.
package dlx_pkg;

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_INC  = 4;

   localparam int unsigned OPCODE_LSB = 0;
   localparam int unsigned OPCODE_W   = 6;
   localparam int unsigned RD_LSB     = 6;
   localparam int unsigned RD_W       = 5;
   localparam int unsigned RS1_LSB    = 11;
   localparam int unsigned RS1_W      = 5;
   localparam int unsigned RS2_LSB    = 16;
   localparam int unsigned RS2_W      = 5;
   localparam int unsigned FUNC_LSB   = 27;
   localparam int unsigned FUNC_W     = 5;

   localparam logic [OPCODE_W-1:0] OP_ALU   = 6'h00;
   localparam logic [FUNC_W-1:0]   FUNC_NOP = 5'h15;

   // ALU-class word with every register field zero and the nop function code.
   localparam logic [INSTR_W-1:0] DLX_NOP_WORD =
      {FUNC_NOP, {(FUNC_LSB - OPCODE_W){1'b0}}, OP_ALU};

   typedef enum logic [1:0] {
      RSP_NONE,
      RSP_DROP,
      RSP_ACCEPT
   } rsp_kind_e;

endpackage

// File: rtl/dlx_fetch_fifo.sv
// In-order word queue between instruction memory and decode; the head entry
// is presented combinationally from storage, and flush empties it in one cycle.
module dlx_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_pop;

   assign do_pop = pop && (count != '0);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // NOTE: storage is not reset; the head is masked to zero while the queue is empty instead.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wdata;
   end

   assign rdata = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/dlx_fetch.sv
// DLX instruction fetch: sequential PC generation, pipelined memory requests,
// in-order buffering toward decode and redirect with stale-response discard.
module dlx_fetch
   import dlx_pkg::*;
#(
   parameter int unsigned         PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned         DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_gnt,
   input  logic                imem_rvalid,
   input  logic [INSTR_W-1:0]  imem_rdata,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [PC_WIDTH-1:0] instr_pc,
   input  logic                instr_ready
);

   localparam int unsigned         CW      = $clog2(DEPTH) + 1;
   localparam int unsigned         SW      = CW + 2;
   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INC);

   logic [PC_WIDTH-1:0]         fetch_pc;
   logic [PC_WIDTH-1:0]         rsp_pc;
   logic [PC_WIDTH-1:0]         redirect_pc;
   logic [CW-1:0]               inflight;
   logic [CW-1:0]               drop;
   logic [CW-1:0]               count;
   logic [SW-1:0]               occupancy;
   logic                        active;
   logic                        transfer;
   logic                        accept;
   rsp_kind_e                   rsp_kind;
   logic [INSTR_W+PC_WIDTH-1:0] head;

   assign redirect_pc = {branch_target[PC_WIDTH-1:2], 2'b00};

   // Queued, in-flight and to-be-dropped words together never exceed DEPTH, so a push always fits.
   assign occupancy = SW'(count) + SW'(inflight) + SW'(drop);
   assign imem_req  = active && !branch_taken && (occupancy < SW'(DEPTH));
   assign imem_addr = fetch_pc;
   assign transfer  = imem_req && imem_gnt;

   // NOTE: default assignment first so this combinational block cannot infer a latch.
   always_comb begin
      rsp_kind = RSP_NONE;
      if (imem_rvalid) rsp_kind = (branch_taken || drop != '0) ? RSP_DROP : RSP_ACCEPT;
   end

   assign accept = (rsp_kind == RSP_ACCEPT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active   <= 1'b0;
         fetch_pc <= RESET_PC;
         rsp_pc   <= RESET_PC;
         inflight <= '0;
         drop     <= '0;
      end else begin
         active <= 1'b1;
         if (branch_taken) begin
            // Everything still outstanding becomes stale; a response arriving now retires one of them.
            fetch_pc <= redirect_pc;
            rsp_pc   <= redirect_pc;
            inflight <= '0;
            drop     <= drop + inflight - CW'(imem_rvalid);
         end else begin
            if (transfer)                fetch_pc <= fetch_pc + PC_STEP;
            if (accept)                  rsp_pc   <= rsp_pc + PC_STEP;
            if (rsp_kind == RSP_DROP)    drop     <= drop - 1'b1;
            inflight <= inflight + CW'(transfer) - CW'(accept);
         end
      end
   end

   dlx_fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (INSTR_W + PC_WIDTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (accept),
      .pop   (instr_ready),
      .flush (branch_taken),
      .wdata ({imem_rdata, rsp_pc}),
      .rdata (head),
      .count (count)
   );

   assign instr_valid       = (count != '0);
   assign {instr, instr_pc} = head;

endmodule

// File: tb/tb_dlx_fetch.sv
// Randomised bench for dlx_fetch: an in-order memory model with stale tracking
// and a scoreboard of the word/PC stream decode should see.
module tb_dlx_fetch;
   import dlx_pkg::*;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;

   always #5 clk = ~clk;

   dlx_fetch #(
      .PC_WIDTH (32),
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_gnt      (imem_gnt),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready)
   );

   typedef struct {
      logic [31:0] addr;
      bit          stale;
      int unsigned due;
   } mem_req_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] word;
   } word_t;

   mem_req_t    pend[$];
   word_t       expq[$];
   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;
   int unsigned cyc = 0;
   int unsigned qcount = 0;
   logic [31:0] exp_fetch = RESET_PC;
   bit          active = 1'b0;
   bit          release_rst = 1'b0;

   int unsigned gnt_pct = 100, rv_pct = 100, rdy_pct = 100, br_pct = 0;
   int unsigned lat_min = 1, lat_max = 1;
   bit          force_br = 1'b0;
   logic [31:0] force_tgt = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ DLX_NOP_WORD;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at the falling edge, check settled outputs, then advance the model
   // to what the next rising edge must commit.
   task automatic step();
      logic        br, gnt, rdy, rv, xfer, accept, exp_req;
      logic [31:0] tgt;
      mem_req_t    r;
      @(negedge clk);
      if (release_rst) begin
         rst_n       = 1'b1;
         release_rst = 1'b0;
      end
      br  = force_br || (rst_n && active && ($urandom_range(99) < br_pct));
      tgt = force_br ? force_tgt : $urandom;
      gnt = ($urandom_range(99) < gnt_pct);
      rdy = ($urandom_range(99) < rdy_pct);
      rv  = (pend.size() > 0) && (pend[0].due <= cyc) && ($urandom_range(99) < rv_pct);
      branch_taken  = br;
      branch_target = tgt;
      imem_gnt      = gnt;
      instr_ready   = rdy;
      imem_rvalid   = rv;
      imem_rdata    = rv ? mem_word(pend[0].addr) : $urandom;
      #1;
      exp_req = active && !br && ((pend.size() + qcount) < DEPTH);
      check("imem_req", 64'(imem_req), 64'(exp_req));
      check("instr_valid", 64'(instr_valid), 64'(qcount != 0));
      check("queue_bound", 64'(dut.count <= DEPTH), 64'd1);
      if (exp_req && imem_req) check("imem_addr", 64'(imem_addr), 64'(exp_fetch));

      accept = 1'b0;
      if (rv) begin
         r      = pend.pop_front();
         accept = !br && !r.stale;
      end
      if (!br && rdy && qcount != 0) qcount--;
      if (accept) qcount++;
      xfer = imem_req && gnt;
      if (br) begin
         qcount = 0;
         foreach (pend[i]) pend[i].stale = 1'b1;
         expq.delete();
         exp_fetch = {tgt[31:2], 2'b00};
      end
      if (xfer) begin
         r.addr  = imem_addr;
         r.stale = 1'b0;
         r.due   = cyc + $urandom_range(lat_max, lat_min);
         pend.push_back(r);
         expq.push_back('{pc: exp_fetch, word: mem_word(exp_fetch)});
         exp_fetch = exp_fetch + 32'd4;
      end
      active = rst_n;
      cyc++;
   endtask

   task automatic run(input int unsigned n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic redirect(input logic [31:0] tgt);
      force_br  = 1'b1;
      force_tgt = tgt;
      step();
      force_br  = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   64'(imem_req),    64'd0);
      check({tag, "_valid"}, 64'(instr_valid), 64'd0);
      check({tag, "_instr"}, 64'(instr),       64'd0);
      check({tag, "_pc"},    64'(instr_pc),    64'd0);
   endtask

   // Asynchronous reset away from any clock edge; the memory model shares it.
   task automatic pulse_reset();
      @(negedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      pend.delete();
      expq.delete();
      qcount    = 0;
      exp_fetch = RESET_PC;
      active    = 1'b0;
      run(2);
      release_rst = 1'b1;
      step();
   endtask

   // Scoreboard monitor: every accepted pop must match the oldest surviving expected word.
   initial begin
      word_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && !branch_taken && instr_valid && instr_ready) begin
            if (expq.size() == 0) begin
               check("pop_unexpected", 64'd1, 64'd0);
            end else begin
               e = expq.pop_front();
               check("instr_pc", 64'(instr_pc), 64'(e.pc));
               check("instr",    64'(instr),    64'(e.word));
            end
         end
      end
   end

   initial begin
      int unsigned first_valid;
      logic [31:0] held_addr;

      #2;
      check_reset_outputs("reset");

      // Free run from reset: first word visible three cycles after release.
      release_rst = 1'b1;
      step();
      first_valid = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (instr_valid && first_valid == 0) first_valid = i;
      end
      check("first_valid_cycle", 64'(first_valid), 64'd3);

      // Decode stall: queue fills to DEPTH and requests stop.
      rdy_pct = 0;
      run(10);
      check("stall_req_low", 64'(imem_req), 64'd0);
      check("stall_count", 64'(dut.count), 64'(DEPTH));
      rdy_pct = 100;
      run(10);

      // Redirect with three requests outstanding.
      lat_min = 4;
      lat_max = 4;
      run(6);
      redirect(32'h0000_0103);
      step();
      check("redirect_addr", 64'(imem_addr), 64'h100);
      run(12);

      // Redirect coinciding with a response and a pop.
      lat_min = 1;
      lat_max = 1;
      run(6);
      redirect(32'h0000_0200);
      run(8);

      // Grant withheld: address must hold.
      gnt_pct = 0;
      step();
      held_addr = imem_addr;
      run(5);
      check("gnt_low_addr_hold", 64'(imem_addr), 64'(held_addr));
      gnt_pct = 100;
      run(3);

      // PC wrap across the top of the address space.
      redirect(32'hFFFF_FFF9);
      run(10);

      // Reset mid-operation with words queued and requests outstanding.
      lat_min = 3;
      lat_max = 3;
      rdy_pct = 0;
      run(6);
      pulse_reset();
      rdy_pct = 100;
      lat_min = 1;
      lat_max = 1;
      step();
      check("restart_addr", 64'(imem_addr), 64'(RESET_PC));
      run(10);

      // Randomised segments.
      for (int seg = 0; seg < 30; seg++) begin
         gnt_pct = $urandom_range(100, 30);
         rv_pct  = $urandom_range(100, 30);
         rdy_pct = $urandom_range(100, 20);
         br_pct  = $urandom_range(8, 0);
         lat_min = $urandom_range(2, 1);
         lat_max = lat_min + $urandom_range(2, 0);
         run(100);
         if (seg == 15) pulse_reset();
      end

      br_pct  = 0;
      rdy_pct = 100;
      rv_pct  = 100;
      run(20);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
